// File: rtl/seg_scan_if.sv
// Bundle of the display-data, control and pin-side signals of the 7-segment scanner.
// The master drives the display data and controls; the slave (the scanner) drives the pins.
interface seg_scan_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic [DIGITS-1:0]   blink_mask;
  logic                lz_en;
  logic [3:0]          bright;
  logic                load;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   sel;
  logic                frame_tick;

  modport master (
    output data_in, dp_in, blank_in, blink_mask, lz_en, bright, load,
    input  seg, sel, frame_tick
  );

  modport slave (
    input  data_in, dp_in, blank_in, blink_mask, lz_en, bright, load,
    output seg, sel, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous double buffering,
// leading-zero suppression, per-digit blank/blink and 16-level brightness.
module seg_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic     CLK,
  input  logic     RST,
  seg_scan_if.slave bus
);
  localparam int CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int UNIT = SCAN_DIV / 16;

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   blink;
  } disp_regs_t;

  typedef enum logic {ST_START, ST_SCAN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [FW-1:0]   fcnt;
  logic            blink_ph;
  disp_regs_t      shadow, active;

  logic            slot_end, boundary, dark;
  logic [DIGITS-1:0] supp;
  logic            lz_run;
  logic [3:0]      nib;
  logic [31:0]     on_cyc;
  logic [7:0]      seg_nxt;
  logic [DIGITS-1:0] sel_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end = (cnt == CW'(SCAN_DIV - 1));
  assign boundary = slot_end && (idx == IW'(DIGITS - 1));

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    supp    = '0;
    lz_run  = bus.lz_en;
    // A digit is suppressed only while the whole run above it is suppressed; digit 0 always shows.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run  = lz_run && (active.data[4*i +: 4] == 4'h0) && !active.dp[i];
      supp[i] = lz_run;
    end
    nib     = 4'(active.data >> (4 * idx));
    on_cyc  = (32'(bus.bright) + 32'd1) * 32'(UNIT) - 32'(GUARD);
    dark    = active.blank[idx] || (active.blink[idx] && blink_ph) || supp[idx]
              || !(32'(cnt) < on_cyc);
    seg_nxt = {~active.dp[idx], hex7(nib)};
    sel_nxt = '1;
    if (!dark) sel_nxt[idx] = 1'b0;
    if (dark)  seg_nxt = 8'hFF;
  end

  // NOTE: shadow and active display registers are reset too, so a reset always wipes pending data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= ST_START;
      cnt            <= '0;
      idx            <= '0;
      fcnt           <= '0;
      blink_ph       <= 1'b0;
      shadow         <= '0;
      active         <= '0;
      bus.seg        <= 8'hFF;
      bus.sel        <= '1;
      bus.frame_tick <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the pre-edge state.
      bus.frame_tick <= (state == ST_SCAN) && boundary;
      if (bus.load) shadow <= {bus.data_in, bus.dp_in, bus.blank_in, bus.blink_mask};
      case (state)
        ST_START: begin
          state   <= ST_SCAN;
          bus.seg <= 8'hFF;
          bus.sel <= '1;
        end
        default: begin
          bus.seg <= seg_nxt;
          bus.sel <= sel_nxt;
          if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
          // Commit at every frame boundary so the displayed frame never mixes old and new data.
          if (boundary) begin
            active <= shadow;
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
              fcnt     <= '0;
              blink_ph <= ~blink_ph;
            end else begin
              fcnt <= fcnt + FW'(1);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a frame/slot arithmetic model checked every cycle,
// plus literal expectations at hand-picked scan positions.
module tb_seg_scan_ctrl;
  localparam int DIGITS       = 8;
  localparam int SCAN_DIV     = 32;
  localparam int GUARD        = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;
  localparam logic [7:0] CODE_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  blink;
  } regs_t;

  logic CLK = 1'b0;
  logic RST;
  seg_scan_if #(.DIGITS(DIGITS)) bus();

  seg_scan_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int n_edges = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_out(input int p, input regs_t a, input logic lz,
                                    input logic [3:0] br, output logic [7:0] seg,
                                    output logic [7:0] sel, output logic ft);
    int slot, c, f, on_cyc;
    logic ph, supp, lit;
    logic [3:0] nib;
    logic [7:0] code;
    slot   = (p / SCAN_DIV) % DIGITS;
    c      = p % SCAN_DIV;
    f      = p / FRAME;
    ph     = ((f / BLINK_FRAMES) % 2) == 1;
    on_cyc = (int'(br) + 1) * (SCAN_DIV / 16) - GUARD;
    supp   = lz && (slot != 0);
    for (int j = slot; j < DIGITS; j++)
      if (a.data[4*j +: 4] != 4'h0 || a.dp[j]) supp = 1'b0;
    nib  = a.data[4*slot +: 4];
    code = CODE_TAB[nib];
    lit  = (c < on_cyc) && !a.blank[slot] && !(a.blink[slot] && ph) && !supp;
    seg  = lit ? {~a.dp[slot], code[6:0]} : 8'hFF;
    sel  = lit ? ~(8'd1 << slot) : 8'hFF;
    ft   = (p % FRAME) == FRAME - 1;
  endfunction

  // Model: inputs sampled at the edge, outputs compared at the following falling edge.
  logic       s_rst, s_load, s_lz;
  logic [3:0] s_bright;
  regs_t      s_regs, m_shadow, m_active;
  int         m_n;
  logic [7:0] e_seg, e_sel;
  logic       e_ft;

  initial begin : model
    m_n = 0;
    m_shadow = '0;
    m_active = '0;
    forever begin
      @(posedge CLK);
      s_rst    = RST;
      s_load   = bus.load;
      s_lz     = bus.lz_en;
      s_bright = bus.bright;
      s_regs   = {bus.data_in, bus.dp_in, bus.blank_in, bus.blink_mask};
      @(negedge CLK);
      e_seg = 8'hFF;
      e_sel = 8'hFF;
      e_ft  = 1'b0;
      if (!s_rst || !RST) begin
        m_n      = 0;
        m_shadow = '0;
        m_active = '0;
      end else begin
        m_n++;
        if (m_n >= 2) begin
          model_out(m_n - 2, m_active, s_lz, s_bright, e_seg, e_sel, e_ft);
          if ((m_n - 2) % FRAME == FRAME - 1) m_active = m_shadow;
        end
        if (s_load) m_shadow = s_regs;
      end
      check("model.seg", {24'd0, bus.seg}, {24'd0, e_seg});
      check("model.sel", {24'd0, bus.sel}, {24'd0, e_sel});
      check("model.frame_tick", {31'd0, bus.frame_tick}, {31'd0, e_ft});
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
      n_edges++;
    end
  endtask

  // Advance until the outputs show scan position p (counted from the first lit output).
  task automatic go(input int p);
    while (n_edges < p + 2) step(1);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] blank,
                         input logic [7:0] blink);
    bus.data_in    = d;
    bus.dp_in      = dp;
    bus.blank_in   = blank;
    bus.blink_mask = blink;
    bus.load       = 1'b1;
    step(1);
    bus.load       = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] es, input logic [7:0] esel);
    check({name, ".seg"}, {24'd0, bus.seg}, {24'd0, es});
    check({name, ".sel"}, {24'd0, bus.sel}, {24'd0, esel});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion (t=%0t)", $time);
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    RST            = 1'b1;
    bus.data_in    = '0;
    bus.dp_in      = '0;
    bus.blank_in   = '0;
    bus.blink_mask = '0;
    bus.lz_en      = 1'b0;
    bus.bright     = 4'd15;
    bus.load       = 1'b0;
    #1 RST = 1'b0;
    step(3);
    expect_out("reset", 8'hFF, 8'hFF);
    check("reset.frame_tick", {31'd0, bus.frame_tick}, 32'd0);

    // Release, loading the scan-order pattern on the very first edge.
    RST = 1'b1;
    n_edges = 0;
    do_load(32'h7654_3210, 8'h00, 8'h00, 8'h00);
    expect_out("first_edge", 8'hFF, 8'hFF);
    step(1);
    expect_out("second_edge", 8'hC0, 8'hFE);

    // Frame 1 shows the loaded pattern; 31 lit cycles then one guard cycle per slot.
    go(256);  expect_out("scan.d0", 8'hC0, 8'hFE);
    go(288);  expect_out("scan.d1", 8'hF9, 8'hFD);
    go(510);  expect_out("scan.d7_last_lit", 8'hF8, 8'h7F);
    go(511);  expect_out("scan.d7_guard", 8'hFF, 8'hFF);
    check("scan.frame_tick", {31'd0, bus.frame_tick}, 32'd1);
    go(512);  expect_out("scan.wrap", 8'hC0, 8'hFE);

    // Leading-zero suppression.
    go(520);
    bus.lz_en = 1'b1;
    do_load(32'h0000_0120, 8'h00, 8'h00, 8'h00);
    go(800);  expect_out("lz.d1", 8'hA4, 8'hFD);
    go(832);  expect_out("lz.d2", 8'hF9, 8'hFB);
    go(864);  expect_out("lz.d3", 8'hFF, 8'hFF);
    go(992);  expect_out("lz.d7", 8'hFF, 8'hFF);
    go(1000);
    do_load(32'h0000_0120, 8'h10, 8'h00, 8'h00);
    go(1120); expect_out("lzdp.d3", 8'hC0, 8'hF7);
    go(1152); expect_out("lzdp.d4", 8'h40, 8'hEF);
    go(1184); expect_out("lzdp.d5", 8'hFF, 8'hFF);

    // Brightness: bright=3 gives 7 lit cycles, bright=0 gives 1.
    go(1279); bus.bright = 4'd3;
    go(1286); expect_out("bright3.c6", 8'hC0, 8'hFE);
    go(1287); expect_out("bright3.c7", 8'hFF, 8'hFF);
    go(1311); bus.bright = 4'd0;
    go(1312); expect_out("bright0.c0", 8'hA4, 8'hFD);
    go(1313); expect_out("bright0.c1", 8'hFF, 8'hFF);
    go(1320); bus.bright = 4'd15;

    // Double buffering: mid-frame load waits for the boundary.
    go(1390); bus.lz_en = 1'b0;
    go(1399);
    do_load(32'hFFFF_FFFF, 8'h00, 8'h00, 8'h00);
    go(1504); expect_out("dbuf.old", 8'hC0, 8'h7F);
    go(1536); expect_out("dbuf.new_d0", 8'h8E, 8'hFE);
    go(1760); expect_out("dbuf.new_d7", 8'h8E, 8'h7F);

    // A load sampled in the boundary cycle itself lands one frame later.
    go(1790);
    do_load(32'h1111_1111, 8'h00, 8'h00, 8'h00);
    go(1792); expect_out("bload.delayed", 8'h8E, 8'hFE);
    go(2048); expect_out("bload.visible", 8'hF9, 8'hFE);

    // Blink on digit 0: frames 10-11 dark, 9 and 12 lit.
    go(2100);
    do_load(32'h1111_1111, 8'h00, 8'h00, 8'h01);
    go(2304); expect_out("blink.f9", 8'hF9, 8'hFE);
    go(2560); expect_out("blink.f10", 8'hFF, 8'hFF);
    go(2592); expect_out("blink.f10_d1", 8'hF9, 8'hFD);
    go(2816); expect_out("blink.f11", 8'hFF, 8'hFF);
    go(3072); expect_out("blink.f12", 8'hF9, 8'hFE);

    // Reset mid-slot 5 blanks at once and wipes the display registers.
    go(3242);
    RST = 1'b0;
    #1;
    expect_out("async_reset", 8'hFF, 8'hFF);
    step(2);
    expect_out("held_reset", 8'hFF, 8'hFF);
    RST = 1'b1;
    n_edges = 0;
    step(2);
    expect_out("restart", 8'hC0, 8'hFE);

    // Blink after restart: frames 0-1 lit, 2-3 dark, 4-5 lit.
    go(100);
    do_load(32'h0000_0000, 8'h00, 8'h00, 8'h01);
    go(256);  expect_out("rblink.f1", 8'hC0, 8'hFE);
    go(512);  expect_out("rblink.f2", 8'hFF, 8'hFF);
    go(768);  expect_out("rblink.f3", 8'hFF, 8'hFF);
    go(1024); expect_out("rblink.f4", 8'hC0, 8'hFE);
    go(1280); expect_out("rblink.f5", 8'hC0, 8'hFE);
    go(1535);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed scanner for common-anode 7-segment displays, driving the board's active-low segment and digit-select lines. It displays a hex value per digit with per-digit decimal point, blanking and blinking, leading-zero suppression, and 16-level brightness. Display data is double-buffered and committed only at frame boundaries, so updates never tear. The block sits between application logic and the display pins and replaces fixed-pattern scan logic.

## Interface
- DIGITS, 8: number of digits scanned, 2..16.
- SCAN_DIV, 50000: CLK cycles per digit slot; must be a multiple of 16 and at least 32.
- GUARD, 2: off cycles at the end of every slot for ghosting suppression; 0 ≤ GUARD < SCAN_DIV/16.
- BLINK_FRAMES, 64: complete frames per blink half-period, at least 1.
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-low.
- data_in  in  4*DIGITS  hex nibble per digit; digit i = [4i+3:4i].
- dp_in  in  DIGITS  decimal point enable per digit.
- blank_in  in  DIGITS  force digit i dark.
- blink_mask  in  DIGITS  digit i blinks.
- lz_en  in  1  leading-zero suppression enable; sampled live.
- bright  in  4  brightness 0..15; sampled live.
- load  in  1  single-cycle strobe that captures data_in, dp_in, blank_in and blink_mask into the shadow registers.
- seg  out  8  active-low segments; seg[7]=dp, seg[6:0]=g..a.
- sel  out  DIGITS  active-low digit selects; sel[i] drives digit i.
- frame_tick  out  1  one-cycle pulse on every frame boundary.

## Operation
- Slot counter cnt runs 0..SCAN_DIV-1. Digit index idx advances when cnt==SCAN_DIV-1 and wraps from DIGITS-1 to 0.
- A frame boundary is the cycle where cnt==SCAN_DIV-1 and idx==DIGITS-1.
- Registers are split into shadow (written by load) and active (copied from shadow at every frame boundary). A load in the boundary cycle itself reaches active one frame later.
- The copy happens at every boundary regardless of load, so active always equals shadow after one boundary.
- The on-window within a slot is cnt < on_cyc, where on_cyc = (bright+1)*(SCAN_DIV/16) - GUARD. Outside the on-window, sel is all ones and seg is 8'hFF.
- Digit i is dark for a slot if any of the following hold:
  - active blank[i] is set;
  - active blink_mask[i] is set and blink_ph=1;
  - the digit is suppressed as a leading zero.
- A dark digit drives sel all ones and seg 8'hFF for the whole slot.
- Leading-zero suppression, when lz_en=1:
  - Digit i is suppressed if its nibble is 0, its dp bit is 0, and every higher digit is also suppressed.
  - Digit 0 is never suppressed.
- Decoding for a lit digit:
  - sel = ~(1<<idx).
  - seg[6:0] codes for 0..F are C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (dp bit excluded).
  - seg[7] = ~dp[idx].
- blink_ph toggles after every BLINK_FRAMES frame boundaries. The frame counter wraps at BLINK_FRAMES-1.
- Counter widths are $clog2(SCAN_DIV), $clog2(DIGITS) and $clog2(BLINK_FRAMES), each with a minimum of 1 bit. The on_cyc product is evaluated at full width, never truncated.

## Timing
- Reset values, asynchronous:
  - cnt=0, idx=0, blink_ph=0, blink counter=0;
  - shadow and active registers 0;
  - seg=8'hFF, sel all ones, frame_tick=0.
- seg, sel and frame_tick are registered: they reflect the cnt/idx state of the previous cycle.
- After RST deasserts, the first edge loads cnt=0/idx=0 state. Outputs show digit 0 from the second edge.
- frame_tick is high in the cycle after the boundary cycle. Its period is exactly DIGITS*SCAN_DIV cycles.
- A load becomes visible on seg/sel in the first slot-0 output after the next boundary.
- Reset asserted mid-slot blanks the outputs immediately. Scanning restarts at digit 0, and shadow and active contents are lost.
- Changes on bright or lz_en take effect from the next cycle's comparison, with no glitch beyond one registered cycle.

## Test plan
- Reset check, with DIGITS=8, SCAN_DIV=32, GUARD=1: hold RST low then release.
  - During reset: seg=FF, sel=FF, frame_tick=0.
  - Two edges after release: sel=FE.
- Scan order and code values: load data_in=32'h76543210, bright=15.
  - sel steps FE,FD,…,7F, each active for 31 cycles followed by 1 dark cycle.
  - seg steps C0,F9,A4,B0,99,92,82,F8.
  - frame_tick period is 256 cycles.
- Leading-zero suppression: load 32'h00000120, lz_en=1.
  - Digits 7..3 dark; digits 2,1,0 show F9,A4,C0.
  - Setting dp_in[4]=1 lights digit 4 with seg=40 and digit 3 with C0.
- Brightness: bright=3, SCAN_DIV=32, GUARD=1 gives 7 lit cycles per slot. bright=0 gives 1 lit cycle.
- Double-buffering: pulse load with 32'hFFFFFFFF mid-frame.
  - Digits keep old values until frame_tick, then all show 8E.
  - A load pulsed in the boundary cycle is delayed one more frame.
- Blink and reset: blink_mask=8'h01, BLINK_FRAMES=2.
  - Digit 0 is dark in frames 2–3 and lit in frames 0–1 and 4–5.
  - RST pulsed low mid-slot 5 forces FF/FF at once, and digit 0 restarts after release.
